// File: rtl/bch_block_arbiter.sv
// Two-requester serial arbiter in front of a shared BCH(63,51) encoder.
// Grants whole K-bit blocks and zero-pads blocks whose message ends early.
module bch_block_arbiter #(
  parameter int unsigned K = 51
) (
  input  logic clk,
  input  logic rst,
  input  logic s0_valid,
  input  logic s0_data,
  input  logic s0_last,
  output logic s0_ready,
  input  logic s1_valid,
  input  logic s1_data,
  input  logic s1_last,
  output logic s1_ready,
  output logic enc_valid,
  output logic enc_data,
  input  logic enc_ready,
  output logic grant_id,
  output logic busy,
  output logic block_done
);

  typedef enum logic [1:0] {StArb, StStream, StPad} state_e;

  localparam logic [5:0] CntMax = 6'(K - 1);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       grant_q, grant_d;
  logic       last_q, last_d;
  logic       done_q, done_d;

  logic sel_valid, sel_data, sel_last;

  assign sel_valid = grant_q ? s1_valid : s0_valid;
  assign sel_data  = grant_q ? s1_data  : s0_data;
  assign sel_last  = grant_q ? s1_last  : s0_last;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    last_d    = last_q;
    done_d    = 1'b0;
    enc_valid = 1'b0;
    enc_data  = 1'b0;
    s0_ready  = 1'b0;
    s1_ready  = 1'b0;
    unique case (state_q)
      StArb: begin
        if (s0_valid || s1_valid) begin
          // On a tie the requester that did not own the previous block wins.
          grant_d = (s0_valid && s1_valid) ? ~last_q : s1_valid;
          last_d  = grant_d;
          cnt_d   = '0;
          state_d = StStream;
        end
      end
      StStream: begin
        enc_valid = sel_valid;
        enc_data  = sel_data;
        s0_ready  = ~grant_q & enc_ready;
        s1_ready  = grant_q & enc_ready;
        if (sel_valid && enc_ready) begin
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = StArb;
          end else begin
            cnt_d = cnt_q + 6'd1;
            if (sel_last) begin
              state_d = StPad;
            end
          end
        end
      end
      StPad: begin
        enc_valid = 1'b1;
        if (enc_ready) begin
          if (cnt_q == CntMax) begin
            cnt_d   = '0;
            done_d  = 1'b1;
            state_d = StArb;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: state_d = StArb;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StArb;
      cnt_q   <= '0;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign grant_id   = grant_q;
  assign busy       = (state_q != StArb);
  assign block_done = done_q;

endmodule

// File: tb/tb_bch_block_arbiter.sv
// Bench for bch_block_arbiter: randomized messages from both requesters, scored
// against a queue-based model of block ownership, padding and alternation.
module tb_bch_block_arbiter;

  localparam int K = 51;

  logic clk = 1'b0;
  logic rst;
  logic s0_valid, s0_data, s0_last, s0_ready;
  logic s1_valid, s1_data, s1_last, s1_ready;
  logic enc_valid, enc_data, enc_ready;
  logic grant_id, busy, block_done;

  bch_block_arbiter #(.K(K)) dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_data(s0_data), .s0_last(s0_last), .s0_ready(s0_ready),
    .s1_valid(s1_valid), .s1_data(s1_data), .s1_last(s1_last), .s1_ready(s1_ready),
    .enc_valid(enc_valid), .enc_data(enc_data), .enc_ready(enc_ready),
    .grant_id(grant_id), .busy(busy), .block_done(block_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Pending message bits per requester; the head is what the requester presents.
  bit q0_d[$], q0_l[$], q1_d[$], q1_l[$];
  int gate0 = 100, gate1 = 100;
  int rdy_mode = 0;
  int par_hold = 0;
  bit mon_en = 1'b0;

  // Model of the block currently owned, plus last winner for tie-breaks.
  bit m_in_blk, m_owner, m_pad, m_last, m_done_exp, m_arb_exp, pv0, pv1;
  int m_cnt;
  int n_xfer, n_done, n_pad, n_blocks;
  int exp_blocks, exp_bits;
  int grants[$];
  bit mx, mg, mb, ml, mo;

  // Requester and encoder-ready drivers.
  initial begin
    s0_valid = 0; s0_data = 0; s0_last = 0;
    s1_valid = 0; s1_data = 0; s1_last = 0;
    enc_ready = 0;
    forever begin
      @(posedge clk); #1;
      s0_valid = (q0_d.size() > 0) && (int'($urandom_range(99)) < gate0);
      s0_data  = (q0_d.size() > 0) ? q0_d[0] : 1'b0;
      s0_last  = (q0_l.size() > 0) ? q0_l[0] : 1'b0;
      s1_valid = (q1_d.size() > 0) && (int'($urandom_range(99)) < gate1);
      s1_data  = (q1_d.size() > 0) ? q1_d[0] : 1'b0;
      s1_last  = (q1_l.size() > 0) ? q1_l[0] : 1'b0;
      if (par_hold > 0) begin
        enc_ready = 1'b0;
        par_hold--;
      end else if (rdy_mode == 1) begin
        enc_ready = (int'($urandom_range(99)) < 70);
      end else begin
        enc_ready = 1'b1;
      end
    end
  end

  // Scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (mon_en && !rst) begin
      mx = enc_valid && enc_ready;
      checks++;
      if (block_done !== m_done_exp) begin
        failures++;
        $display("FAIL block_done: got %b want %b at %0t", block_done, m_done_exp, $time);
      end
      if (block_done === 1'b1) n_done++;
      m_done_exp = 1'b0;
      if (m_arb_exp) begin
        checks++;
        if (busy !== 1'b0) begin
          failures++;
          $display("FAIL arb_gap: busy got %b want 0 at %0t", busy, $time);
        end
        m_arb_exp = 1'b0;
      end else if (busy === 1'b1 && !m_in_blk) begin
        mg = (pv0 && pv1) ? ~m_last : pv1;
        checks++;
        if (!(pv0 || pv1) || grant_id !== mg) begin
          failures++;
          $display("FAIL grant: got %b want %b (valids %b%b) at %0t", grant_id, mg, pv1, pv0,
                   $time);
        end
        m_in_blk = 1'b1; m_owner = mg; m_cnt = 0; m_pad = 1'b0; m_last = mg;
        grants.push_back(int'(grant_id));
        n_blocks++;
      end
      if (busy !== 1'b1) begin
        checks++;
        if (enc_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0) begin
          failures++;
          $display("FAIL idle_outputs: enc_valid=%b s0_ready=%b s1_ready=%b want 0 at %0t",
                   enc_valid, s0_ready, s1_ready, $time);
        end
      end
      if (m_in_blk) begin
        checks++;
        if (busy !== 1'b1 || grant_id !== m_owner) begin
          failures++;
          $display("FAIL hold: busy=%b grant=%b want 1/%b at %0t", busy, grant_id, m_owner, $time);
        end
        mo = m_owner ? s0_ready : s1_ready;
        checks++;
        if (mo !== 1'b0 || (m_pad && (s0_ready !== 1'b0 || s1_ready !== 1'b0 || enc_valid !== 1'b1)))
        begin
          failures++;
          $display("FAIL ready_mask: s0_ready=%b s1_ready=%b enc_valid=%b pad=%b at %0t",
                   s0_ready, s1_ready, enc_valid, m_pad, $time);
        end
      end
      if (mx) begin
        n_xfer++;
        checks++;
        if (!m_in_blk) begin
          failures++;
          $display("FAIL xfer_outside: transfer with no block owned at %0t", $time);
        end else begin
          mb = 1'b0;
          if (m_pad) begin
            n_pad++;
          end else begin
            ml = m_owner ? (s1_valid && s1_ready) : (s0_valid && s0_ready);
            if (!ml) begin
              failures++;
              $display("FAIL src_handshake: owner %b not accepted at %0t", m_owner, $time);
            end else if (m_owner) begin
              mb = q1_d.pop_front();
              ml = q1_l.pop_front();
            end else begin
              mb = q0_d.pop_front();
              ml = q0_l.pop_front();
            end
            if (ml && m_cnt < K - 1) m_pad = 1'b1;
          end
          checks++;
          if (enc_data !== mb) begin
            failures++;
            $display("FAIL enc_data: got %b want %b bit %0d at %0t", enc_data, mb, m_cnt, $time);
          end
          m_cnt++;
          if (m_cnt == K) begin
            m_in_blk = 1'b0; m_done_exp = 1'b1; m_arb_exp = 1'b1;
            if (rdy_mode == 2) par_hold = 12;
          end
        end
      end else begin
        checks++;
        if ((s0_valid && s0_ready) || (s1_valid && s1_ready)) begin
          failures++;
          $display("FAIL src_without_enc: source accepted with no encoder transfer at %0t", $time);
        end
      end
      pv0 = s0_valid;
      pv1 = s1_valid;
    end
  end

  task automatic model_reset();
    q0_d.delete(); q0_l.delete(); q1_d.delete(); q1_l.delete();
    m_in_blk = 0; m_owner = 0; m_pad = 0; m_last = 1; m_done_exp = 0; m_arb_exp = 0;
    pv0 = 0; pv1 = 0; m_cnt = 0; par_hold = 0;
    gate0 = 100; gate1 = 100; rdy_mode = 0;
    grants.delete();
    n_xfer = 0; n_done = 0; n_pad = 0; n_blocks = 0; exp_blocks = 0; exp_bits = 0;
  endtask

  task automatic do_reset();
    @(negedge clk); #2;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic load(input int src, input int len);
    for (int i = 1; i <= len; i++) begin
      if (src == 0) begin
        q0_d.push_back(1'($urandom_range(1)));
        q0_l.push_back(i == len);
      end else begin
        q1_d.push_back(1'($urandom_range(1)));
        q1_l.push_back(i == len);
      end
    end
    exp_blocks += (len + K - 1) / K;
    exp_bits += len;
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #2;
      if (q0_d.size() == 0 && q1_d.size() == 0 && !m_in_blk && !m_arb_exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    mon_en = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy: got %b want 0", busy); end
    checks++;
    if (block_done !== 1'b0) begin failures++; $display("FAIL rst_done: got %b want 0", block_done); end
    checks++;
    if (enc_valid !== 1'b0) begin failures++; $display("FAIL rst_enc_valid: got %b want 0", enc_valid); end
    checks++;
    if (s0_ready !== 1'b0) begin failures++; $display("FAIL rst_s0_ready: got %b want 0", s0_ready); end
    checks++;
    if (s1_ready !== 1'b0) begin failures++; $display("FAIL rst_s1_ready: got %b want 0", s1_ready); end
    checks++;
    if (grant_id !== 1'b0) begin failures++; $display("FAIL rst_grant: got %b want 0", grant_id); end
    mon_en = 1'b1;
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    do_reset();
    load(0, 51);
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL single_timeout: got busy want idle"); end
    checks++; if (n_xfer != 51) begin failures++; $display("FAIL single_xfers: got %0d want 51", n_xfer); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL single_done: got %0d want 1", n_done); end
    checks++;
    if (grants.size() != 1 || grants[0] != 0) begin
      failures++; $display("FAIL single_grant: got %0d grants want one grant to 0", grants.size());
    end
  endtask

  task automatic test_alternate();
    bit ok;
    do_reset();
    load(0, 3 * K);
    load(1, 3 * K);
    wait_idle(1500, ok);
    checks++; if (!ok) begin failures++; $display("FAIL alt_timeout: got busy want idle"); end
    checks++;
    if (grants.size() != 6) begin failures++; $display("FAIL alt_count: got %0d want 6", grants.size()); end
    for (int i = 0; i < grants.size(); i++) begin
      checks++;
      if (grants[i] != i % 2) begin
        failures++; $display("FAIL alt_order: block %0d got %0d want %0d", i, grants[i], i % 2);
      end
    end
    checks++; if (n_pad != 0) begin failures++; $display("FAIL alt_pad: got %0d want 0", n_pad); end
  endtask

  task automatic test_short();
    bit ok;
    do_reset();
    load(1, 20);
    wait_idle(400, ok);
    checks++; if (!ok) begin failures++; $display("FAIL short_timeout: got busy want idle"); end
    checks++; if (n_pad != 31) begin failures++; $display("FAIL short_pad: got %0d want 31", n_pad); end
    checks++; if (n_done != 1) begin failures++; $display("FAIL short_done: got %0d want 1", n_done); end
    checks++;
    if (grants.size() != 1 || grants[0] != 1) begin
      failures++; $display("FAIL short_grant: got %0d grants want one grant to 1", grants.size());
    end
  endtask

  task automatic test_parity();
    bit ok;
    do_reset();
    rdy_mode = 2;
    for (int i = 0; i < 3; i++) begin
      load(0, int'($urandom_range(140, 10)));
      load(1, int'($urandom_range(140, 10)));
    end
    wait_idle(8000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL parity_timeout: got busy want idle"); end
    checks++;
    if (n_blocks != exp_blocks || n_done != exp_blocks) begin
      failures++;
      $display("FAIL parity_blocks: got %0d/%0d want %0d", n_blocks, n_done, exp_blocks);
    end
    checks++;
    if (n_pad != exp_blocks * K - exp_bits) begin
      failures++; $display("FAIL parity_pad: got %0d want %0d", n_pad, exp_blocks * K - exp_bits);
    end
    rdy_mode = 0;
  endtask

  task automatic test_random_stall();
    bit ok;
    do_reset();
    rdy_mode = 1;
    gate0 = 50;
    gate1 = 80;
    for (int i = 0; i < 3; i++) begin
      load(0, int'($urandom_range(160, 5)));
      load(1, int'($urandom_range(100, 5)));
    end
    wait_idle(15000, ok);
    checks++; if (!ok) begin failures++; $display("FAIL stall_timeout: got busy want idle"); end
    checks++;
    if (n_xfer != exp_blocks * K) begin
      failures++; $display("FAIL stall_xfers: got %0d want %0d", n_xfer, exp_blocks * K);
    end
    checks++;
    if (n_pad != exp_blocks * K - exp_bits) begin
      failures++; $display("FAIL stall_pad: got %0d want %0d", n_pad, exp_blocks * K - exp_bits);
    end
  endtask

  task automatic test_mid_reset();
    bit ok;
    bit hit;
    do_reset();
    load(0, 100);
    hit = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk); #2;
      if (m_in_blk && m_cnt == 30) begin
        hit = 1'b1;
        break;
      end
    end
    checks++; if (!hit) begin failures++; $display("FAIL midrst_reach: got no cnt=30 want cnt=30"); end
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || enc_valid !== 1'b0 || s0_ready !== 1'b0 || s1_ready !== 1'b0 ||
        block_done !== 1'b0 || grant_id !== 1'b0) begin
      failures++;
      $display("FAIL midrst_outputs: busy=%b enc_valid=%b rdy=%b%b done=%b grant=%b want all 0",
               busy, enc_valid, s1_ready, s0_ready, block_done, grant_id);
    end
    #2 rst = 1'b0;
    load(0, K);
    load(1, K);
    wait_idle(600, ok);
    checks++; if (!ok) begin failures++; $display("FAIL midrst_timeout: got busy want idle"); end
    checks++;
    if (grants.size() != 2 || grants[0] != 0 || grants[1] != 1) begin
      failures++; $display("FAIL midrst_grant: got %0d grants want 0 then 1", grants.size());
    end
    checks++; if (n_done != 2) begin failures++; $display("FAIL midrst_done: got %0d want 2", n_done); end
  endtask

  initial begin
    rst = 1'b1;
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_short();
    test_parity();
    test_random_stall();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
